// File: rtl/sd_lane_pkg.sv
// -----------------------------------------------------------------------------
// sd_lane_pkg
// Shared types and constants for the SD lane responder.
//   sd_lane_state_t : responder FSM states
//   SD_OK/SD_TIMEOUT/SD_INJECT/SD_RANGE : 2-bit lane error codes
//   WORDS_PER_BLOCK / PTR_W : block geometry (128 words, 7-bit pointer)
//   blk_width()      : address bits needed to select one of n blocks
// -----------------------------------------------------------------------------
package sd_lane_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_BUSY   = 3'd1,
    ST_RD_STREAM = 3'd2,
    ST_WR_STREAM = 3'd3,
    ST_WR_COMMIT = 3'd4
  } sd_lane_state_t;

  localparam logic [1:0] SD_OK      = 2'b00;
  localparam logic [1:0] SD_TIMEOUT = 2'b01;
  localparam logic [1:0] SD_INJECT  = 2'b10;
  localparam logic [1:0] SD_RANGE   = 2'b11;

  localparam int WORDS_PER_BLOCK = 128;
  localparam int PTR_W           = 7;

  // A single-block store still needs one address bit to keep slices legal.
  function automatic int blk_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_lane_mem.sv
// -----------------------------------------------------------------------------
// sd_lane_mem
// Block store for one SD lane: NUM_BLOCKS x 128 words x 32 bits, addressed
// {block, word pointer}. Synchronous write, asynchronous (combinational) read,
// no reset: contents are undefined until written and survive a lane reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   addr     in   {block, ptr}
//   wr_data  in   32-bit write data
//   rd_data  out  32-bit word at addr
// -----------------------------------------------------------------------------
module sd_lane_mem
  import sd_lane_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = blk_width(NUM_BLOCKS) + PTR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data
);

  localparam int DEPTH = NUM_BLOCKS * WORDS_PER_BLOCK;

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/sd_lane_responder.sv
// -----------------------------------------------------------------------------
// sd_lane_responder
// Card-side model of one striped SD lane. Accepts block read/write commands,
// streams 128-word blocks out on reads, absorbs them on writes, models access
// latency and reports a 2-bit lane error code.
// Optional feature macro: SD_LANE_ERR_INJECT_EN adds input inject_err, which
// tags an accepted command with error code 10 while it still runs normally.
// Ports:
//   clk             in   rising-edge clock
//   n_rst           in   asynchronous active-low reset
//   sd_start        in   command strobe (IDLE only)
//   sd_mode         in   1 = read, 0 = write
//   sd_block_no     in   32-bit block address
//   sd_read_enable  in   consume current read word
//   sd_write_enable in   write sd_in at current pointer
//   sd_in           in   32-bit write data
//   inject_err      in   (SD_LANE_ERR_INJECT_EN only) error injection
//   sd_out          out  read data, 0 outside RD_STREAM
//   sd_ready        out  high in IDLE / RD_STREAM / WR_STREAM
//   sd_error        out  00 ok, 01 timeout, 10 injected, 11 out of range
// -----------------------------------------------------------------------------
module sd_lane_responder
  import sd_lane_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int ACCESS_LAT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sd_start,
  input  logic        sd_mode,
  input  logic [31:0] sd_block_no,
  input  logic        sd_read_enable,
  input  logic        sd_write_enable,
  input  logic [31:0] sd_in,
`ifdef SD_LANE_ERR_INJECT_EN
  input  logic        inject_err,
`endif
  output logic [31:0] sd_out,
  output logic        sd_ready,
  output logic [1:0]  sd_error
);

  localparam int BLK_W = blk_width(NUM_BLOCKS);
  localparam int LAT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam int ST_W  = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(WORDS_PER_BLOCK - 1);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(ACCESS_LAT - 1);
  localparam logic [ST_W-1:0]  STALL_LAST = ST_W'(TIMEOUT - 1);

  sd_lane_state_t   state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [ST_W-1:0]  stall_q, stall_d;
  logic [1:0]       err_q, err_d;

  logic             mem_we;
  logic [31:0]      mem_rd_data;
  logic [1:0]       start_err;

`ifdef SD_LANE_ERR_INJECT_EN
  assign start_err = inject_err ? SD_INJECT : SD_OK;
`else
  assign start_err = SD_OK;
`endif

  sd_lane_mem #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .addr    ({blk_q, ptr_q}),
    .wr_data (sd_in),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      blk_q   <= '0;
      lat_q   <= '0;
      stall_q <= '0;
      err_q   <= SD_OK;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      blk_q   <= blk_d;
      lat_q   <= lat_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    blk_d   = blk_q;
    lat_d   = lat_q;
    stall_d = stall_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sd_start) begin
          // Full 32-bit compare so high address bits cannot alias a block.
          if (sd_block_no >= 32'(NUM_BLOCKS)) begin
            err_d = SD_RANGE;
          end else begin
            err_d   = start_err;
            ptr_d   = '0;
            lat_d   = '0;
            stall_d = '0;
            blk_d   = sd_block_no[BLK_W-1:0];
            state_d = sd_mode ? ST_RD_BUSY : ST_WR_STREAM;
          end
        end
      end

      ST_RD_BUSY: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_RD_STREAM;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_RD_STREAM: begin
        if (sd_read_enable) begin
          stall_d = '0;
          ptr_d   = ptr_q + PTR_W'(1);   // wraps to 0 after the last word
          if (ptr_q == PTR_LAST) begin
            state_d = ST_IDLE;
          end
        end else if (stall_q == STALL_LAST) begin
          stall_d = '0;
          ptr_d   = '0;
          err_d   = SD_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          stall_d = stall_q + ST_W'(1);
        end
      end

      ST_WR_STREAM: begin
        if (sd_write_enable) begin
          mem_we  = 1'b1;
          stall_d = '0;
          ptr_d   = ptr_q + PTR_W'(1);
          if (ptr_q == PTR_LAST) begin
            lat_d   = '0;
            state_d = ST_WR_COMMIT;
          end
        end else if (stall_q == STALL_LAST) begin
          // Words already written stay in memory.
          stall_d = '0;
          ptr_d   = '0;
          err_d   = SD_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          stall_d = stall_q + ST_W'(1);
        end
      end

      ST_WR_COMMIT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sd_out   = (state_q == ST_RD_STREAM) ? mem_rd_data : 32'h0;
  assign sd_ready = (state_q == ST_IDLE) || (state_q == ST_RD_STREAM) ||
                    (state_q == ST_WR_STREAM);
  assign sd_error = err_q;

endmodule

// File: tb/tb_sd_lane_responder.sv
// -----------------------------------------------------------------------------
// tb_sd_lane_responder
// Directed bench for sd_lane_responder with default parameters
// (NUM_BLOCKS=8, ACCESS_LAT=4, TIMEOUT=255). Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sd_lane_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        n_rst;
  logic        sd_start;
  logic        sd_mode;
  logic [31:0] sd_block_no;
  logic        sd_read_enable;
  logic        sd_write_enable;
  logic [31:0] sd_in;
  logic [31:0] sd_out;
  logic        sd_ready;
  logic [1:0]  sd_error;
`ifdef SD_LANE_ERR_INJECT_EN
  logic        inject_err;
`endif

  int checks   = 0;
  int failures = 0;

  sd_lane_responder dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .sd_start        (sd_start),
    .sd_mode         (sd_mode),
    .sd_block_no     (sd_block_no),
    .sd_read_enable  (sd_read_enable),
    .sd_write_enable (sd_write_enable),
    .sd_in           (sd_in),
`ifdef SD_LANE_ERR_INJECT_EN
    .inject_err      (inject_err),
`endif
    .sd_out          (sd_out),
    .sd_ready        (sd_ready),
    .sd_error        (sd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a command for one edge; returns at the following negedge.
  task automatic issue(input logic mode, input logic [31:0] blk);
    sd_start    = 1'b1;
    sd_mode     = mode;
    sd_block_no = blk;
    @(negedge clk);
    sd_start    = 1'b0;
  endtask

  // Expect exactly LAT not-ready cycles, then ready again.
  task automatic expect_busy(input string tag);
    int b;
    b = 0;
    for (int k = 0; k < LAT; k++) begin
      if (!sd_ready) b++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, b, LAT);
    check({tag, "_ready_after"}, 32'(sd_ready), 1);
  endtask

  initial begin
    int rdy;
    n_rst           = 1'b0;
    sd_start        = 1'b0;
    sd_mode         = 1'b0;
    sd_block_no     = '0;
    sd_read_enable  = 1'b0;
    sd_write_enable = 1'b0;
    sd_in           = '0;
`ifdef SD_LANE_ERR_INJECT_EN
    inject_err      = 1'b0;
`endif

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(sd_ready), 1);
    check("rst_out",   sd_out, 0);
    check("rst_err",   32'(sd_error), 0);
    n_rst = 1'b1;
    @(negedge clk);
    $display("reset released");

    // ---------------- write block 3 ----------------
    issue(1'b0, 32'd3);
    check("wr_start_ready", 32'(sd_ready), 1);
    check("wr_start_err",   32'(sd_error), 0);
    check("wr_out_zero",    sd_out, 0);
    rdy = 0;
    for (int i = 0; i < 128; i++) begin
      if (sd_ready) rdy++;
      sd_write_enable = 1'b1;
      sd_in           = 32'h66666666 + 32'(i);
      @(negedge clk);
    end
    sd_write_enable = 1'b0;
    check("wr_ready_cnt", rdy, 128);
    expect_busy("wr_commit");
    $display("write block 3: 128 words");

    // ---------------- read block 3 with illegal inputs ----------------
    issue(1'b1, 32'd3);
    expect_busy("rd");
    for (int i = 0; i < 128; i++) begin
      check($sformatf("rd_data_%0d", i), sd_out, 32'h66666666 + 32'(i));
      sd_read_enable = 1'b1;
      if (i == 10) begin
        sd_start        = 1'b1;
        sd_mode         = 1'b0;
        sd_block_no     = 32'd5;
        sd_write_enable = 1'b1;
        sd_in           = 32'hDEADBEEF;
      end else begin
        sd_start        = 1'b0;
        sd_write_enable = 1'b0;
      end
      @(negedge clk);
    end
    sd_read_enable = 1'b0;
    check("rd_end_ready", 32'(sd_ready), 1);
    check("rd_end_out",   sd_out, 0);
    check("rd_end_err",   32'(sd_error), 0);
    $display("read block 3: 128 words");

    // ---------------- out of range ----------------
    issue(1'b1, 32'd8);
    check("oor_err",   32'(sd_error), 3);
    check("oor_ready", 32'(sd_ready), 1);
    @(negedge clk);
    check("oor_sticky", 32'(sd_error), 3);
    check("oor_idle",   32'(sd_ready), 1);
    $display("start block 8: out of range");

    // ---------------- timeout on a stalled read ----------------
    issue(1'b1, 32'd3);
    check("to_err_clr", 32'(sd_error), 0);
    expect_busy("to");
    for (int i = 0; i < 11; i++) begin
      check($sformatf("to_data_%0d", i), sd_out, 32'h66666666 + 32'(i));
      sd_read_enable = 1'b1;
      @(negedge clk);
    end
    sd_read_enable = 1'b0;
    check("to_data_11", sd_out, 32'h66666671);
    repeat (254) @(negedge clk);
    check("to_254_out", sd_out, 32'h66666671);
    check("to_254_err", 32'(sd_error), 0);
    @(negedge clk);
    check("to_err",   32'(sd_error), 1);
    check("to_out",   sd_out, 0);
    check("to_ready", 32'(sd_ready), 1);
    $display("read block 3: stalled, timeout");

    // ---------------- reset mid-write ----------------
    issue(1'b0, 32'd5);
    check("rw_err_clr", 32'(sd_error), 0);
    for (int i = 0; i < 50; i++) begin
      sd_write_enable = 1'b1;
      sd_in           = 32'hA5000000 + 32'(i);
      @(negedge clk);
    end
    sd_write_enable = 1'b0;
    n_rst = 1'b0;
    #1;
    check("rw_rst_ready", 32'(sd_ready), 1);
    check("rw_rst_out",   sd_out, 0);
    check("rw_rst_err",   32'(sd_error), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    $display("write block 5: reset at word 50");

    issue(1'b1, 32'd5);
    expect_busy("rr");
    for (int i = 0; i < 50; i++) begin
      check($sformatf("rr_data_%0d", i), sd_out, 32'hA5000000 + 32'(i));
      sd_read_enable = 1'b1;
      @(negedge clk);
    end
    sd_read_enable = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("final_ready", 32'(sd_ready), 1);
    check("final_out",   sd_out, 0);
    $display("read block 5: words 0..49");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_lane_responder.md
# sd_lane_responder

Synthesizable responder for one SD lane of the RAID5 array: it is the card-side end of the striped SD interface that `raid_top` drives. It accepts block commands (`sd_start`, `sd_mode`, `sd_block_no`), streams 128-word blocks out on reads, absorbs 128-word blocks on writes, models access latency and reports the 2-bit lane error code. Three instances, one each on `sd1`/`sd2`/`sd3`, form the storage model for system-level simulation and FPGA bring-up.

## Interface
- `NUM_BLOCKS`, 8: blocks stored; addressable range is 0..NUM_BLOCKS-1.
- `ACCESS_LAT`, 4: busy cycles before a read stream and after a write commit; minimum 1.
- `TIMEOUT`, 255: consecutive stalled stream cycles before abort; minimum 1.
- `clk`  in  1  rising-edge clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `sd_start`  in  1  command strobe; sampled only in IDLE.
- `sd_mode`  in  1  1 = read, 0 = write; latched with `sd_start`.
- `sd_block_no`  in  32  block address; latched with `sd_start`.
- `sd_read_enable`  in  1  consumes the current read word.
- `sd_write_enable`  in  1  writes `sd_in` at the current pointer.
- `sd_in`  in  32  write data from RAID.
- `sd_out`  out  32  read data to RAID; 0 outside RD_STREAM.
- `sd_ready`  out  1  high in IDLE, RD_STREAM and WR_STREAM.
- `sd_error`  out  2  00 ok, 01 timeout, 10 injected, 11 address out of range.

## Operation
- States: IDLE, RD_BUSY, RD_STREAM, WR_STREAM, WR_COMMIT.
- IDLE with `sd_start`=1:
  - `sd_block_no` ≥ NUM_BLOCKS: `sd_error`=11, stay in IDLE.
  - Otherwise clear `sd_error`, clear the 7-bit word pointer, then go to RD_BUSY (read) or WR_STREAM (write).
- RD_BUSY: `sd_ready`=0 for ACCESS_LAT cycles, then RD_STREAM.
- RD_STREAM: `sd_out` = mem[blk][ptr].
  - `sd_read_enable`=1 increments `ptr`.
  - `sd_read_enable` with `ptr`=127 returns the block to IDLE; the pointer wraps to 0.
- WR_STREAM: `sd_write_enable`=1 writes `sd_in` to mem[blk][ptr] and increments `ptr`. The write at `ptr`=127 moves the block to WR_COMMIT.
- WR_COMMIT: `sd_ready`=0 for ACCESS_LAT cycles, then IDLE.
- Stall counter:
  - Cleared on every enable; counts stream cycles with no enable.
  - Reaching TIMEOUT forces `sd_error`=01 and a return to IDLE.
  - A partial write stays in memory.
- Ignored inputs:
  - `sd_start` outside IDLE.
  - `sd_read_enable` outside RD_STREAM.
  - `sd_write_enable` outside WR_STREAM.
  - Both enables high at once: only the one matching the state acts.
- `sd_error` is sticky until the next accepted `sd_start`.
- Memory is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `sd_ready`=1, `sd_out`=0, `sd_error`=00, pointer and counters 0.
- Reset mid-stream aborts immediately; memory keeps every word already written.
- `sd_start` at edge N: `sd_ready` is low from cycle N+1 for ACCESS_LAT cycles on a read; it stays high on a write.
- Read: word 0 is valid on `sd_out` in the first RD_STREAM cycle. An enable at edge M shows the next word after edge M.
- Back-to-back enables give one word per cycle; a full block with no stalls takes 128 cycles.
- Write: the word is captured at the same edge that sees `sd_write_enable`.
- An out-of-range error is visible the cycle after `sd_start`.

## Configuration
- `SD_LANE_ERR_INJECT_EN` defined:
  - Adds input `inject_err` (1 bit).
  - `inject_err`=1 on an accepted `sd_start` sets `sd_error`=10.
  - The command otherwise runs normally, so RAID degraded-mode reconstruction can be exercised.
- Not defined: the port is absent and code 10 is never produced.

## Structure
- Package `sd_lane_pkg`:
  - state enum `sd_lane_state_t`;
  - error constants SD_OK, SD_TIMEOUT, SD_INJECT, SD_RANGE;
  - WORDS_PER_BLOCK = 128 and PTR_W = 7.
- Sub-module `sd_lane_mem`: single-port synchronous-write, asynchronous-read RAM of NUM_BLOCKS×128×32, addressed {block, ptr}.
- The FSM, pointer, latency counter and stall counter stay in `sd_lane_responder`.

## Test plan
- Write path: reset, then write block 3 with words 32'h66666666+i.
  - `sd_ready` stays high for 128 writes, drops for 4 cycles, then returns to IDLE.
- Read path: read block 3.
  - `sd_ready` low for 4 cycles, then `sd_out` = 32'h66666666 through 32'h666666E5 over 128 enables, then IDLE.
- Out of range: `sd_start` with block 8 → `sd_error`=11 the next cycle, `sd_ready` stays 1.
- Timeout: read stream stalled for 255 cycles → `sd_error`=01, IDLE, `sd_out`=0.
- Reset mid-write: `n_rst` low at word 50 → IDLE with all outputs at reset values. A re-read of that block returns words 0..49 as written.
- Illegal inputs: `sd_start` during RD_STREAM and `sd_write_enable` during a read → both ignored, and the read data sequence is unchanged.
